// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory access arbiter.
// Optional grant statistics are enabled with the MEM_ARB_STATS_EN macro.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 32;
   localparam int SEL_W_DEF  = 4;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CLEAR
   } state_t;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: rr_ptr breaks ties, a lone request always wins.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic       winner,
   output logic       any
);

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      any    = |req;
      winner = PORT_CPU;
      if (&req)
         winner = rr_ptr;
      else if (req[1])
         winner = PORT_DBG;
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port data Memory between the CPU and the debug/DMA loader,
// and sequencing the Memory clear. Define MEM_ARB_STATS_EN to add saturating per-port grant counters.
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [SEL_W-1:0]  sel0,
   input  logic [SEL_W-1:0]  sel1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   input  logic              clr_req,
   output logic              clr_ack,
`ifdef MEM_ARB_STATS_EN
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1,
`endif
   output logic              mem_str,
   output logic              mem_ld,
   output logic              mem_clr,
   output logic [SEL_W-1:0]  mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   state_t              state, state_nxt;
   logic                rr_ptr;
   logic                winner, any;
   logic                take;
   logic                lat_port, lat_we;
   logic [SEL_W-1:0]    lat_sel;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

   rr_arb2 u_rr_arb2 (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .any    (any)
   );

   // A pending clear pre-empts any port request in IDLE.
   assign take = (state == IDLE) && !clr_req && any;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   // NOTE: the request latch is reset along with the FSM so mem_* never shows stale X after reset.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         rr_ptr    <= PORT_CPU;
         lat_port  <= PORT_CPU;
         lat_we    <= 1'b0;
         lat_sel   <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            lat_port  <= winner;
            lat_we    <= we[winner];
            lat_sel   <= winner ? sel1   : sel0;
            lat_addr  <= winner ? addr1  : addr0;
            lat_wdata <= winner ? wdata1 : wdata0;
            rr_ptr    <= ~winner;
         end
      end
   end

   // Load data is captured at the end of ACCESS while mem_ld is still asserted.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= '0;
         if (state == ACCESS && !lat_we) begin
            rvalid <= port_onehot(lat_port);
            rdata  <= mem_dout;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt       = '0;
      clr_ack   = 1'b0;
      mem_str   = 1'b0;
      mem_ld    = 1'b0;
      mem_clr   = 1'b0;
      mem_sel   = '0;
      mem_addr  = '0;
      mem_din   = '0;
      case (state)
         IDLE: begin
            if (clr_req)
               state_nxt = CLEAR;
            else if (any)
               state_nxt = ACCESS;
         end
         ACCESS: begin
            gnt       = port_onehot(lat_port);
            mem_str   = lat_we;
            mem_ld    = ~lat_we;
            mem_sel   = lat_sel;
            mem_addr  = lat_addr;
            mem_din   = lat_wdata;
            state_nxt = IDLE;
         end
         CLEAR: begin
            mem_clr   = 1'b1;
            clr_ack   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MEM_ARB_STATS_EN
   // Counters advance at the end of each ACCESS cycle and stick at all-ones.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else if (state == CLEAR) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else if (state == ACCESS) begin
         if (lat_port == PORT_CPU && gnt_cnt0 != 16'hFFFF)
            gnt_cnt0 <= gnt_cnt0 + 16'd1;
         if (lat_port == PORT_DBG && gnt_cnt1 != 16'hFFFF)
            gnt_cnt1 <= gnt_cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed testbench for mem_access_arbiter with a small byte-lane memory model.
// Grant-counter checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_access_arbiter;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   logic              clk = 1'b0;
   logic              clr_n = 1'b0;
   logic [1:0]        req = '0;
   logic [1:0]        we = '0;
   logic [SEL_W-1:0]  sel0 = '0, sel1 = '0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic [1:0]        gnt, rvalid;
   logic [DATA_W-1:0] rdata;
   logic              clr_req = 1'b0;
   logic              clr_ack;
   logic              mem_str, mem_ld, mem_clr;
   logic [SEL_W-1:0]  mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din, mem_dout;
`ifdef MEM_ARB_STATS_EN
   logic [15:0]       gnt_cnt0, gnt_cnt1;
`endif

   int passed = 0;
   int total  = 0;

   logic [DATA_W-1:0] mem [0:15];

   always #5 clk = ~clk;

   mem_access_arbiter dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .req      (req),
      .we       (we),
      .sel0     (sel0),
      .sel1     (sel1),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .clr_req  (clr_req),
      .clr_ack  (clr_ack),
`ifdef MEM_ARB_STATS_EN
      .gnt_cnt0 (gnt_cnt0),
      .gnt_cnt1 (gnt_cnt1),
`endif
      .mem_str  (mem_str),
      .mem_ld   (mem_ld),
      .mem_clr  (mem_clr),
      .mem_sel  (mem_sel),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   // Memory model: combinational read while mem_ld, byte-lane write and full clear on the rising edge.
   assign mem_dout = mem_ld ? mem[mem_addr[3:0]] : '0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (mem_str) begin
         for (int b = 0; b < SEL_W; b++)
            if (mem_sel[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_din[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_n = 1'b0; req = '0; we = '0; clr_req = 1'b0;
      tick();
      clr_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if ({gnt, rvalid, clr_ack, mem_str, mem_ld, mem_clr} !== 9'b0)
         $display("FAIL reset_ctrl: got %b want 0", {gnt, rvalid, clr_ack, mem_str, mem_ld, mem_clr}); else passed++;
      total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else passed++;
      total++; if ({mem_sel, mem_addr, mem_din} !== '0)
         $display("FAIL reset_mem_bus: sel %h addr %h din %h want 0", mem_sel, mem_addr, mem_din); else passed++;
   endtask

   task automatic test_store_load();
      req = 2'b01; we = 2'b01; sel0 = 4'hF; addr0 = 20'd1; wdata0 = 32'h11111111;
      tick();
      total++; if (gnt !== 2'b01) $display("FAIL t1_st_gnt: got %b want 01", gnt); else passed++;
      total++; if ({mem_str, mem_ld} !== 2'b10) $display("FAIL t1_st_strobe: got %b want 10", {mem_str, mem_ld}); else passed++;
      total++; if (mem_addr !== 20'd1) $display("FAIL t1_st_addr: got %h want 1", mem_addr); else passed++;
      total++; if (mem_din !== 32'h11111111) $display("FAIL t1_st_din: got %h want 11111111", mem_din); else passed++;
      total++; if (mem_sel !== 4'hF) $display("FAIL t1_st_sel: got %h want f", mem_sel); else passed++;
      req = 2'b00;
      tick();
      total++; if ({gnt, mem_str} !== 3'b0) $display("FAIL t1_idle: got %b want 000", {gnt, mem_str}); else passed++;
      req = 2'b01; we = 2'b00;
      tick();
      total++; if ({gnt, mem_ld} !== 3'b011) $display("FAIL t1_ld_gnt: got %b want 011", {gnt, mem_ld}); else passed++;
      req = 2'b00;
      tick();
      total++; if (rvalid !== 2'b01) $display("FAIL t1_rvalid: got %b want 01", rvalid); else passed++;
      total++; if (rdata !== 32'h11111111) $display("FAIL t1_rdata: got %h want 11111111", rdata); else passed++;
      tick();
      total++; if (rvalid !== 2'b00) $display("FAIL t1_rvalid_pulse: got %b want 00", rvalid); else passed++;
      total++; if (rdata !== 32'h11111111) $display("FAIL t1_rdata_hold: got %h want 11111111", rdata); else passed++;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_port;
      do_reset();
      mem[2] = 32'h22222222;
      mem[3] = 32'h33333333;
      req = 2'b11; we = 2'b00; addr0 = 20'd2; addr1 = 20'd3;
      tick();
      total++; if (gnt !== 2'b01) $display("FAIL t2_first_gnt: got %b want 01", gnt); else passed++;
      req = 2'b10;
      tick();
      total++; if ({rvalid, rdata} !== {2'b01, 32'h22222222})
         $display("FAIL t2_first_rd: got %b/%h want 01/22222222", rvalid, rdata); else passed++;
      tick();
      total++; if (gnt !== 2'b10) $display("FAIL t2_second_gnt: got %b want 10", gnt); else passed++;
      req = 2'b00;
      tick();
      total++; if ({rvalid, rdata} !== {2'b10, 32'h33333333})
         $display("FAIL t2_second_rd: got %b/%h want 10/33333333", rvalid, rdata); else passed++;
      // A lone port0 access leaves the pointer favouring port1 for the held-request run.
      req = 2'b01;
      tick();
      req = 2'b00;
      tick();
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_port = (k % 2 == 0) ? 2'b10 : 2'b01;
         tick();
         total++; if (gnt !== exp_port) $display("FAIL t2_alt_gnt%0d: got %b want %b", k, gnt, exp_port); else passed++;
         if (k == 3) req = 2'b00;
         tick();
         total++; if (rvalid !== exp_port) $display("FAIL t2_alt_rvalid%0d: got %b want %b", k, rvalid, exp_port); else passed++;
      end
   endtask

   task automatic test_byte_lanes();
      req = 2'b10; we = 2'b10; sel1 = 4'b0101; addr1 = 20'd2; wdata1 = 32'hAAAAAAAA;
      tick();
      total++; if ({gnt, mem_str, mem_sel} !== {2'b10, 1'b1, 4'b0101})
         $display("FAIL t3_st: got %b/%b/%b want 10/1/0101", gnt, mem_str, mem_sel); else passed++;
      req = 2'b00;
      tick();
      // Store with no lanes enabled still runs a granted cycle.
      req = 2'b01; we = 2'b01; sel0 = 4'h0; addr0 = 20'd2; wdata0 = 32'h0;
      tick();
      total++; if ({gnt, mem_str, mem_sel} !== {2'b01, 1'b1, 4'h0})
         $display("FAIL t3_sel0: got %b/%b/%h want 01/1/0", gnt, mem_str, mem_sel); else passed++;
      req = 2'b00;
      tick();
      req = 2'b10; we = 2'b00;
      tick();
      req = 2'b00;
      tick();
      total++; if ({rvalid, rdata} !== {2'b10, 32'h22AA22AA})
         $display("FAIL t3_merge: got %b/%h want 10/22aa22aa", rvalid, rdata); else passed++;
   endtask

   task automatic test_clear();
      clr_req = 1'b1; req = 2'b01; we = 2'b00; addr0 = 20'd1;
      tick();
      total++; if ({mem_clr, clr_ack, gnt} !== 4'b1100)
         $display("FAIL t4_clear: got %b want 1100", {mem_clr, clr_ack, gnt}); else passed++;
      clr_req = 1'b0;
      tick();
      total++; if ({mem_clr, clr_ack, gnt} !== 4'b0000)
         $display("FAIL t4_ack_pulse: got %b want 0000", {mem_clr, clr_ack, gnt}); else passed++;
      tick();
      total++; if ({gnt, mem_ld} !== 3'b011) $display("FAIL t4_gnt_after: got %b want 011", {gnt, mem_ld}); else passed++;
      req = 2'b00;
      tick();
      total++; if ({rvalid, rdata} !== {2'b01, 32'h0})
         $display("FAIL t4_cleared_rd: got %b/%h want 01/0", rvalid, rdata); else passed++;
   endtask

   task automatic test_reset_mid_access();
      req = 2'b11; we = 2'b00; addr0 = 20'd1; addr1 = 20'd3;
      tick();
      total++; if ({gnt, mem_ld} !== 3'b101) $display("FAIL t5_pre_gnt: got %b want 101", {gnt, mem_ld}); else passed++;
      #2;
      clr_n = 1'b0;
      #1;
      total++; if ({gnt, mem_str, mem_ld, mem_clr} !== 5'b0)
         $display("FAIL t5_drop: got %b want 00000", {gnt, mem_str, mem_ld, mem_clr}); else passed++;
      total++; if ({mem_sel, mem_addr, mem_din} !== '0)
         $display("FAIL t5_bus: sel %h addr %h din %h want 0", mem_sel, mem_addr, mem_din); else passed++;
      req = 2'b00;
      tick();
      clr_n = 1'b1;
      total++; if (rvalid !== 2'b00) $display("FAIL t5_no_rvalid: got %b want 00", rvalid); else passed++;
      tick();
      total++; if (rvalid !== 2'b00) $display("FAIL t5_no_rvalid_late: got %b want 00", rvalid); else passed++;
      req = 2'b11;
      tick();
      total++; if (gnt !== 2'b01) $display("FAIL t5_ptr_reset: got %b want 01", gnt); else passed++;
      req = 2'b00;
      tick();
   endtask

`ifdef MEM_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      we = 2'b00;
      for (int k = 0; k < 4; k++) begin
         req = (k == 3) ? 2'b10 : 2'b01;
         tick();
         req = 2'b00;
         tick();
      end
      total++; if (gnt_cnt0 !== 16'd3) $display("FAIL t6_cnt0: got %0d want 3", gnt_cnt0); else passed++;
      total++; if (gnt_cnt1 !== 16'd1) $display("FAIL t6_cnt1: got %0d want 1", gnt_cnt1); else passed++;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      total++; if ({gnt_cnt0, gnt_cnt1} !== 32'h0)
         $display("FAIL t6_cnt_clear: got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1); else passed++;
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset();
      test_store_load();
      test_round_robin();
      test_byte_lanes();
      test_clear();
      test_reset_mid_access();
`ifdef MEM_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
